// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// EX-stage forwarding select codes and the default register address width.
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_AW = 3;

    // FSM state encoding
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] FLUSH    = 2'd2;

    // EX operand source select
    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   master : datapath side, supplies stage register addresses / control bits,
//            receives latch enables, flushes, forwarding selects and status.
//   slave  : hazard controller side.
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 8
);

    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use1;
    logic              id_use2;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;
    logic              mem_reg_write;
    logic              wb_reg_write;
    logic              branch_taken;
    logic              mem_req;
    logic              mem_ready;

    logic              pc_en;
    logic              l1_en;
    logic              l2_en;
    logic              l3_en;
    logic              l4_en;
    logic              l1_flush;
    logic              l2_flush;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              mem_err;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_use1, id_use2,
        output ex_rs1, ex_rs2, ex_rd, ex_mem_read,
        output mem_rd, wb_rd, mem_reg_write, wb_reg_write,
        output branch_taken, mem_req, mem_ready,
        input  pc_en, l1_en, l2_en, l3_en, l4_en,
        input  l1_flush, l2_flush, fwd_a, fwd_b, mem_err, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use1, id_use2,
        input  ex_rs1, ex_rs2, ex_rd, ex_mem_read,
        input  mem_rd, wb_rd, mem_reg_write, wb_reg_write,
        input  branch_taken, mem_req, mem_ready,
        output pc_en, l1_en, l2_en, l3_en, l4_en,
        output l1_flush, l2_flush, fwd_a, fwd_b, mem_err, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// -----------------------------------------------------------------------------
// fwd_unit
// Combinational operand forwarding select for one EX source register.
//   ex_rs                   : EX source register
//   mem_rd / mem_reg_write  : MEM-stage destination and write flag
//   wb_rd  / wb_reg_write   : WB-stage destination and write flag
//   fwd                     : FWD_MEM, FWD_WB or FWD_RF (MEM is the younger
//                             result, so it wins over WB)
// -----------------------------------------------------------------------------
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] ex_rs,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_reg_write,
    input  logic [AW-1:0] wb_rd,
    input  logic          wb_reg_write,
    output fwd_sel_t      fwd
);

    // R0 is hard-wired zero, so a write to it never forwards
    always_comb begin
        fwd = FWD_RF;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs)) begin
            fwd = FWD_MEM;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and sequencing controller for the 8-bit pipelined processor.
// Drives the PC / stage-latch enables and the IF/ID, ID/EX flushes, the EX
// operand forwarding selects, and holds the pipeline while a data-memory
// access is outstanding (with timeout abort).
//   clk1   : pipeline clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : pipe_hazard_ctrl_if.slave (stage addresses/controls in,
//            enables/flushes/forwarding/status out)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic                     clk1,
    input  logic                     rst_n,
    pipe_hazard_ctrl_if.slave        bus
);

    import pipe_pkg::*;

    localparam int               TO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q,     state_d;
    logic [TO_W-1:0]  to_cnt_q,    to_cnt_d;
    logic             mem_err_q,   mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic     lu;
    logic     front_en;   // PC and IF/ID latch
    logic     back_en;    // ID/EX, EX/MEM, MEM/WB latches
    logic     l1_flush;
    logic     l2_flush;
    fwd_sel_t fwd_a_raw;
    fwd_sel_t fwd_b_raw;

    always_comb begin
        lu = bus.ex_mem_read && (bus.ex_rd != '0) &&
             ((bus.id_use1 && (bus.id_rs1 == bus.ex_rd)) ||
              (bus.id_use2 && (bus.id_rs2 == bus.ex_rd)));

        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        mem_err_d = mem_err_q;
        front_en  = 1'b1;
        back_en   = 1'b1;
        l1_flush  = 1'b0;
        l2_flush  = 1'b0;

        case (state_q)
            RUN: begin
                // Memory hold outranks branch, which outranks load-use
                if (bus.mem_req && !bus.mem_ready) begin
                    front_en = 1'b0;
                    back_en  = 1'b0;
                    to_cnt_d = TO_W'(1);
                    state_d  = MEM_WAIT;
                end else if (bus.branch_taken) begin
                    l1_flush = 1'b1;
                    l2_flush = 1'b1;
                    state_d  = FLUSH;
                end else if (lu) begin
                    // Hold IF/ID, let the load advance, bubble into ID/EX
                    front_en = 1'b0;
                    l2_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    to_cnt_d = '0;
                    state_d  = RUN;
                end else if (to_cnt_q == TO_LAST) begin
                    // Abort: release the pipeline without retrying the access
                    mem_err_d = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = RUN;
                end else begin
                    front_en = 1'b0;
                    back_en  = 1'b0;
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                // EX holds a bubble here, so branch_taken is not acted on
                l1_flush = 1'b1;
                state_d  = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (!rst_n) begin
            front_en = 1'b0;
            back_en  = 1'b0;
            l1_flush = 1'b0;
            l2_flush = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (!front_en && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            to_cnt_q    <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    fwd_unit #(.AW(REG_AW)) u_fwd_a (
        .ex_rs         (bus.ex_rs1),
        .mem_rd        (bus.mem_rd),
        .mem_reg_write (bus.mem_reg_write),
        .wb_rd         (bus.wb_rd),
        .wb_reg_write  (bus.wb_reg_write),
        .fwd           (fwd_a_raw)
    );

    fwd_unit #(.AW(REG_AW)) u_fwd_b (
        .ex_rs         (bus.ex_rs2),
        .mem_rd        (bus.mem_rd),
        .mem_reg_write (bus.mem_reg_write),
        .wb_rd         (bus.wb_rd),
        .wb_reg_write  (bus.wb_reg_write),
        .fwd           (fwd_b_raw)
    );

    assign bus.pc_en     = front_en;
    assign bus.l1_en     = front_en;
    assign bus.l2_en     = back_en;
    assign bus.l3_en     = back_en;
    assign bus.l4_en     = back_en;
    assign bus.l1_flush  = l1_flush;
    assign bus.l2_flush  = l2_flush;
    assign bus.fwd_a     = rst_n ? fwd_a_raw : FWD_RF;
    assign bus.fwd_b     = rst_n ? fwd_b_raw : FWD_RF;
    assign bus.mem_err   = mem_err_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 8-bit pipelined processor. It watches register addresses and control bits in the ID, EX, MEM and WB stages and drives the per-stage latch enables and flushes. It also drives the EX-stage operand forwarding selects and holds the whole pipeline while a data-memory access is outstanding. It sits beside the stage latches (L1..L4) and is the only source of their enable and flush controls.

Parameters:
REG_AW, 3, register-file address width (8 registers; R0 hard-wired zero)
MEM_TIMEOUT, 15, maximum cycles in MEM_WAIT before abort
CNT_W, 8, width of the stall statistics counter

Ports:
clk1  in  1  pipeline clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID
id_use1, id_use2  in  1  ID instruction actually reads rs1 / rs2
ex_rs1, ex_rs2  in  REG_AW  source registers of the instruction in EX
ex_rd  in  REG_AW  destination register in EX
ex_mem_read  in  1  EX instruction is a load
mem_rd, wb_rd  in  REG_AW  destination registers in MEM / WB
mem_reg_write, wb_reg_write  in  1  MEM / WB instruction writes the register file
branch_taken  in  1  branch resolved taken in EX this cycle
mem_req  in  1  MEM stage has a data-memory access
mem_ready  in  1  data memory completes the access this cycle
pc_en, l1_en, l2_en, l3_en, l4_en  out  1  PC and stage-latch enables
l1_flush, l2_flush  out  1  insert a bubble (zero control) into IF/ID, ID/EX
fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 from MEM, 10 from WB
mem_err  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- The FSM has three states: RUN, MEM_WAIT, FLUSH. It is the only sequential logic besides the timeout counter, mem_err and stall_cnt. All other outputs decode combinationally from the state and the current inputs.
- Reset (asynchronous, rst_n=0):
  - state=RUN, timeout counter=0, mem_err=0, stall_cnt=0.
  - While rst_n=0, all enables are 0, both flushes are 0, and fwd_a=fwd_b=00.
- Load-use hazard (lu):
  - lu = ex_mem_read, and ex_rd!=0, and ex_rd matches id_rs1 with id_use1=1 or id_rs2 with id_use2=1.
- Priority when events coincide: memory wait first, then branch, then load-use.
- RUN state:
  - If mem_req=1 and mem_ready=0: all enables are 0 this cycle; next state is MEM_WAIT; the timeout counter loads 1.
  - Else if branch_taken=1: all enables are 1; l1_flush=1 and l2_flush=1; next state is FLUSH. A coincident lu is discarded.
  - Else if lu=1: pc_en=0 and l1_en=0; l2_en, l3_en and l4_en are 1; l2_flush=1. This inserts one bubble with zero added latency, and the state stays RUN.
  - Otherwise all enables are 1 and both flushes are 0.
- MEM_WAIT state:
  - All enables are 0 every cycle and the timeout counter increments.
  - When mem_ready=1: enables are 1 in that same cycle, and the next state is RUN.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0: mem_err is set (sticky until reset), enables are 1 for that cycle, and the next state is RUN. The aborted access is not retried.
- FLUSH state:
  - One cycle long. All enables are 1 and l1_flush=1, which kills the second wrong-path fetch. Next state is RUN.
  - A branch_taken arriving in FLUSH is ignored, because the instruction in EX is a bubble.
- Forwarding (combinational, independent of the FSM):
  - fwd_a=01 if mem_reg_write=1, mem_rd!=0 and mem_rd==ex_rs1.
  - Else fwd_a=10 if wb_reg_write=1, wb_rd!=0 and wb_rd==ex_rs1.
  - Else fwd_a=00.
  - fwd_b follows the same rules against ex_rs2. MEM has priority over WB.
- stall_cnt:
  - Increments on every cycle in which pc_en=0. It saturates at 2^CNT_W-1 and does not wrap.
- Reset asserted mid-MEM_WAIT or mid-FLUSH: the block returns to RUN immediately, with no pending bubble retained.

Decomposition:
- Shared package pipe_pkg: FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, FLUSH=2'd2), forwarding select constants FWD_RF/FWD_MEM/FWD_WB, and REG_AW.
- One natural sub-module: fwd_unit. It is purely combinational and is instantiated once per operand.

Test Plan:
- Reset release, no hazards, mem_req=0 -> all enables are 1, flushes 0, fwd 00, stall_cnt 0.
- ex_mem_read=1, ex_rd=3, id_rs2=3, id_use2=1 -> exactly one cycle with pc_en=l1_en=0 and l2_flush=1; stall_cnt=1; the next cycle is normal.
- branch_taken=1 together with the same load-use -> l1_flush=l2_flush=1 in cycle N, then l1_flush=1 only in cycle N+1, no stall, stall_cnt unchanged.
- mem_req=1 with mem_ready low for 4 cycles, then high -> enables are 0 for 4 cycles and 1 on the mem_ready cycle; stall_cnt=4; mem_err=0.
- mem_req=1, mem_ready never asserted -> exactly MEM_TIMEOUT stalled cycles (15), mem_err=1 and stays 1; rst_n pulse clears it.
- mem_rd=wb_rd=5 (both writing), ex_rs1=5, ex_rs2=0 -> fwd_a=01, fwd_b=00; with mem_reg_write=0 -> fwd_a=10.
